// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, forward-select codes and the ID/EX register layout
package cpu_pkg;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OPW = 4;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Everything the ID/EX register carries from decode into execute
  typedef struct packed {
    logic           regwr;
    logic           memrd;
    logic           memwr;
    logic           alusrc1;
    logic           alusrc2;
    logic [AW-1:0]  wr_addr;
    logic [OPW-1:0] aluop;
    logic [1:0]     rs_fwd;
    logic [1:0]     rt_fwd;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [DW-1:0]  imm;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - three-way operand forwarding mux (MEM result, WB data, register file)
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::DW
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] reg_data,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] out_data
);

  // The one-ahead producer is the newest value, so the MEM bit wins (11 behaves as 10)
  always_comb begin
    out_data = reg_data;
    if (sel[1]) begin
      out_data = mem_data;
    end else if (sel == FWD_WB) begin
      out_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with operand forwarding and load-use bubble (optional ID_EX_STALL_CNT_EN stall counter)
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int DW  = cpu_pkg::DW,
  parameter int AW  = cpu_pkg::AW,
  parameter int OPW = cpu_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_in,
  input  logic           flush,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic [AW-1:0]  id_rs_addr,
  input  logic [AW-1:0]  id_rt_addr,
  input  logic [AW-1:0]  id_wr_addr,
  input  logic           id_regwr,
  input  logic           id_memrd,
  input  logic           id_memwr,
  input  logic           id_alusrc1,
  input  logic           id_alusrc2,
  input  logic [OPW-1:0] id_aluop,
  input  logic [1:0]     id_rs_fwd,
  input  logic [1:0]     id_rt_fwd,
  input  logic [DW-1:0]  mem_alu_result,
  input  logic [DW-1:0]  wb_data,
  output logic           ex_regwr,
  output logic           ex_memrd,
  output logic           ex_memwr,
  output logic [AW-1:0]  ex_wr_addr,
  output logic [OPW-1:0] ex_aluop,
  output logic [DW-1:0]  ex_store_data,
  output logic [DW-1:0]  ex_op_a,
  output logic [DW-1:0]  ex_op_b,
  output logic           load_use_stall
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  id_ex_t        ex_q;
  id_ex_t        id_d;
  logic          rs_hit;
  logic          rt_hit;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

  // Gather the decoded fields into the register layout
  always_comb begin
    id_d         = '0;
    id_d.regwr   = id_regwr;
    id_d.memrd   = id_memrd;
    id_d.memwr   = id_memwr;
    id_d.alusrc1 = id_alusrc1;
    id_d.alusrc2 = id_alusrc2;
    id_d.wr_addr = id_wr_addr;
    id_d.aluop   = id_aluop;
    id_d.rs_fwd  = id_rs_fwd;
    id_d.rt_fwd  = id_rt_fwd;
    id_d.rs_data = id_rs_data;
    id_d.rt_data = id_rt_data;
    id_d.imm     = id_imm;
  end

  // A load in EX whose target the ID instruction actually reads; Rt counts for stores even with an immediate B
  always_comb begin
    rs_hit         = (id_rs_addr == ex_q.wr_addr) && !id_alusrc1;
    rt_hit         = (id_rt_addr == ex_q.wr_addr) && (!id_alusrc2 || id_memwr);
    load_use_stall = ex_q.memrd && (ex_q.wr_addr != '0) && (rs_hit || rt_hit)
                     && !flush && !stall_in;
  end

  // Register update: reset, hold, squash, load-use bubble, else capture ID
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (stall_in) begin
      ex_q <= ex_q;
    end else if (flush || load_use_stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Count inserted load-use bubbles; survives flushes, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (load_use_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  fwd_mux #(.W(DW)) u_rs_mux (
    .sel      (ex_q.rs_fwd),
    .reg_data (ex_q.rs_data),
    .mem_data (mem_alu_result),
    .wb_data  (wb_data),
    .out_data (rs_val)
  );

  fwd_mux #(.W(DW)) u_rt_mux (
    .sel      (ex_q.rt_fwd),
    .reg_data (ex_q.rt_data),
    .mem_data (mem_alu_result),
    .wb_data  (wb_data),
    .out_data (rt_val)
  );

  // EX-stage outputs: registered controls plus operand selection
  always_comb begin
    ex_regwr      = ex_q.regwr;
    ex_memrd      = ex_q.memrd;
    ex_memwr      = ex_q.memwr;
    ex_wr_addr    = ex_q.wr_addr;
    ex_aluop      = ex_q.aluop;
    ex_op_a       = ex_q.alusrc1 ? ex_q.imm : rs_val;
    ex_op_b       = ex_q.alusrc2 ? ex_q.imm : rt_val;
    ex_store_data = rt_val;
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - scoreboard testbench for id_ex_pipe
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr;
  logic        id_regwr, id_memrd, id_memwr, id_alusrc1, id_alusrc2;
  logic [3:0]  id_aluop;
  logic [1:0]  id_rs_fwd, id_rt_fwd;
  logic [31:0] mem_alu_result, wb_data;
  logic        ex_regwr, ex_memrd, ex_memwr;
  logic [4:0]  ex_wr_addr;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_store_data, ex_op_a, ex_op_b;
  logic        load_use_stall;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  localparam int S_REGWR = 0, S_MEMRD = 1, S_MEMWR = 2, S_WR = 3, S_OP = 4,
                 S_A = 5, S_B = 6, S_ST = 7, S_LU = 8, S_CNT = 9;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wr_addr(id_wr_addr),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_aluop(id_aluop),
    .id_rs_fwd(id_rs_fwd), .id_rt_fwd(id_rt_fwd),
    .mem_alu_result(mem_alu_result), .wb_data(wb_data),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .ex_wr_addr(ex_wr_addr), .ex_aluop(ex_aluop), .ex_store_data(ex_store_data),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .load_use_stall(load_use_stall)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_REGWR: actual = {31'b0, ex_regwr};
      S_MEMRD: actual = {31'b0, ex_memrd};
      S_MEMWR: actual = {31'b0, ex_memwr};
      S_WR:    actual = {27'b0, ex_wr_addr};
      S_OP:    actual = {28'b0, ex_aluop};
      S_A:     actual = ex_op_a;
      S_B:     actual = ex_op_b;
      S_ST:    actual = ex_store_data;
      S_LU:    actual = {31'b0, load_use_stall};
`ifdef ID_EX_STALL_CNT_EN
      S_CNT:   actual = stall_cnt;
`endif
      default: actual = 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || actual(e.sel) !== e.val) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %h expected %h (due cycle %0d)",
                 e.name, cyc, actual(e.sel), e.val, e.cyc);
      end
    end
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] want, input string name);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: direct got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_now(input int sel, input logic [31:0] val, input string name);
    sb.push_back('{cyc, sel, val, name});
  endtask

  task automatic exp_next(input int sel, input logic [31:0] val, input string name);
    sb.push_back('{cyc + 1, sel, val, name});
  endtask

  task automatic set_nop();
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs_addr = '0; id_rt_addr = '0; id_wr_addr = '0;
    id_regwr = 0; id_memrd = 0; id_memwr = 0; id_alusrc1 = 0; id_alusrc2 = 0;
    id_aluop = '0; id_rs_fwd = 2'b00; id_rt_fwd = 2'b00;
  endtask

  task automatic load_lw(input logic [4:0] dst);
    set_nop();
    id_memrd = 1; id_regwr = 1; id_wr_addr = dst; id_alusrc2 = 1; id_imm = 32'h4;
    tick();
  endtask

  initial begin
    rst = 1; stall_in = 0; flush = 0;
    mem_alu_result = 32'hAAAA; wb_data = 32'h5555;
    set_nop();
    id_regwr = 1; id_wr_addr = 5'd3; id_rs_data = 32'h33;

    tick(); tick();
    rst = 0;
    chk({31'b0, ex_regwr}, 32'd0, "d_rst_regwr");
    chk({27'b0, ex_wr_addr}, 32'd0, "d_rst_wr_addr");
    chk(ex_op_a, 32'd0, "d_rst_op_a");
    exp_now(S_REGWR, 0, "rst_regwr");
    exp_now(S_MEMRD, 0, "rst_memrd");
    exp_now(S_WR, 0, "rst_wr_addr");
    exp_now(S_A, 0, "rst_op_a");
    exp_now(S_B, 0, "rst_op_b");
    exp_now(S_ST, 0, "rst_store");
    exp_now(S_LU, 0, "rst_lu");
`ifdef ID_EX_STALL_CNT_EN
    exp_now(S_CNT, 0, "rst_cnt");
`endif

    set_nop();
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_regwr = 1; id_wr_addr = 5'd9; id_aluop = 4'd2;
    exp_next(S_A, 32'h11, "cap_op_a");
    exp_next(S_B, 32'h22, "cap_op_b");
    exp_next(S_ST, 32'h22, "cap_store");
    exp_next(S_REGWR, 1, "cap_regwr");
    exp_next(S_WR, 9, "cap_wr_addr");
    exp_next(S_OP, 2, "cap_aluop");
    tick();
    chk(ex_op_a, 32'h11, "d_cap_op_a");
    chk(ex_op_b, 32'h22, "d_cap_op_b");

    id_rs_fwd = 2'b10; id_rt_fwd = 2'b01;
    exp_next(S_A, 32'hAAAA, "fwd_mem_a");
    exp_next(S_B, 32'h5555, "fwd_wb_b");
    exp_next(S_ST, 32'h5555, "fwd_wb_store");
    tick();
    chk(ex_op_a, 32'hAAAA, "d_fwd_mem_a");
    chk(ex_op_b, 32'h5555, "d_fwd_wb_b");

    id_rs_fwd = 2'b11; id_alusrc2 = 1; id_imm = 32'h7;
    exp_next(S_A, 32'hAAAA, "fwd11_a");
    exp_next(S_B, 32'h7, "imm_b");
    exp_next(S_ST, 32'h5555, "imm_store");
    tick();
    chk(ex_op_b, 32'h7, "d_imm_b");
    chk(ex_store_data, 32'h5555, "d_imm_store");

    load_lw(5'd8);
    exp_now(S_MEMRD, 1, "lw_in_ex");
    set_nop();
    id_rs_addr = 5'd8; id_rt_addr = 5'd3; id_regwr = 1; id_wr_addr = 5'd10;
    id_rs_data = 32'h1234; id_rt_data = 32'h20;
    #1;
    chk({31'b0, load_use_stall}, 32'd1, "d_lu_rs");
    exp_now(S_LU, 1, "lu_rs");
    exp_next(S_REGWR, 0, "lu_bubble_regwr");
    exp_next(S_MEMRD, 0, "lu_bubble_memrd");
    exp_next(S_WR, 0, "lu_bubble_wr");
`ifdef ID_EX_STALL_CNT_EN
    exp_next(S_CNT, 1, "lu_cnt1");
`endif
    tick();
    chk({31'b0, ex_regwr}, 32'd0, "d_lu_bubble_regwr");
    id_rs_fwd = 2'b01; wb_data = 32'h99;
    exp_now(S_LU, 0, "lu_one_cycle");
    exp_next(S_A, 32'h99, "lu_fwd_a");
    exp_next(S_B, 32'h20, "lu_fwd_b");
    exp_next(S_REGWR, 1, "lu_resume_regwr");
    exp_next(S_WR, 10, "lu_resume_wr");
    tick();
    chk(ex_op_a, 32'h99, "d_lu_fwd_a");

    load_lw(5'd8);
    set_nop();
    id_rs_addr = 5'd8; id_alusrc1 = 1; id_rt_addr = 5'd8; id_alusrc2 = 1; id_regwr = 1;
    exp_now(S_LU, 0, "lu_imm_no_hazard");
    tick();

    load_lw(5'd8);
    set_nop();
    id_rt_addr = 5'd8; id_alusrc2 = 1; id_memwr = 1; id_imm = 32'h8;
    exp_now(S_LU, 1, "lu_store_rt");
    exp_next(S_MEMWR, 0, "lu_store_bubble");
`ifdef ID_EX_STALL_CNT_EN
    exp_next(S_CNT, 2, "lu_cnt2");
`endif
    tick();
    exp_now(S_LU, 0, "lu_store_release");
    exp_next(S_MEMWR, 1, "lu_store_captured");
    tick();

    load_lw(5'd0);
    set_nop();
    id_regwr = 1; id_wr_addr = 5'd4;
    #1;
    chk({31'b0, load_use_stall}, 32'd0, "d_lu_reg0");
    exp_now(S_LU, 0, "lu_reg0");
    tick();

    load_lw(5'd8);
    set_nop();
    id_rs_addr = 5'd8; id_regwr = 1; id_wr_addr = 5'd12; flush = 1;
    exp_now(S_LU, 0, "lu_flush_mask");
    exp_next(S_REGWR, 0, "flush_bubble");
`ifdef ID_EX_STALL_CNT_EN
    exp_next(S_CNT, 2, "flush_cnt_hold");
`endif
    tick();
    flush = 0;

    set_nop();
    id_regwr = 1; id_wr_addr = 5'd5; id_aluop = 4'd3; id_rs_data = 32'h77; id_rt_data = 32'h66;
    tick();
    stall_in = 1; flush = 1;
    id_wr_addr = 5'd6; id_aluop = 4'd1; id_rs_data = 32'h88;
    exp_next(S_REGWR, 1, "hold_regwr");
    exp_next(S_WR, 5, "hold_wr");
    exp_next(S_OP, 3, "hold_aluop");
    exp_next(S_A, 32'h77, "hold_op_a");
    tick();
    chk({27'b0, ex_wr_addr}, 32'd5, "d_hold_wr");
    stall_in = 0;
    exp_next(S_REGWR, 0, "prio_flush_regwr");
    exp_next(S_WR, 0, "prio_flush_wr");
    tick();
    chk({31'b0, ex_regwr}, 32'd0, "d_prio_flush_regwr");
    flush = 0;
    exp_next(S_REGWR, 1, "resume_regwr");
    exp_next(S_WR, 6, "resume_wr");
    exp_next(S_A, 32'h88, "resume_op_a");
    tick();
    chk(ex_op_a, 32'h88, "d_resume_op_a");

    repeat (3) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h", e.name, e.val);
    end
    if (n_fail == 0) $display("PASS");
    else $display("FAIL");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
